// File: rtl/cic_conv_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cic_conv_if
// Description : Bundle of the signals between the CIC conversion controller,
//               the CIC wrapper and the register/readout logic.
//               master : request/config inputs, CIC sample stream and the
//                        result_ready side of the result handshake
//                        (drives start, abort, continuous, avg_log2,
//                        cic_valid, cic_data, result_ready).
//               slave  : the controller itself (drives cic_reset_n, result,
//                        result_valid, busy, overrun).
// Revision    : 1.0 - initial release
// ============================================================================
interface cic_conv_if #(
    parameter int NUMBITS = 25
);
    logic               start;
    logic               abort;
    logic               continuous;
    logic [2:0]         avg_log2;
    logic               cic_valid;
    logic [NUMBITS-1:0] cic_data;
    logic               cic_reset_n;
    logic [NUMBITS-1:0] result;
    logic               result_valid;
    logic               result_ready;
    logic               busy;
    logic               overrun;

    modport master (
        output start, abort, continuous, avg_log2, cic_valid, cic_data,
               result_ready,
        input  cic_reset_n, result, result_valid, busy, overrun
    );

    modport slave (
        input  start, abort, continuous, avg_log2, cic_valid, cic_data,
               result_ready,
        output cic_reset_n, result, result_valid, busy, overrun
    );
endinterface
`default_nettype wire

// File: rtl/cic_conv_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cic_conv_ctrl
// Description : Conversion controller for a third-order CIC decimator.
//               Holds the CIC in reset while idle, flushes it for
//               FLUSH_CYCLES after a start request, drops DISCARD settling
//               outputs, then averages 2^avg_log2 decimated samples and
//               presents each average on a valid/ready handshake.
//               Single-shot and continuous modes.
// Ports       : clk      - modulator-rate clock
//               reset_n  - synchronous active-low reset
//               bus      - cic_conv_if.slave: start/abort/continuous/avg_log2
//                          requests, cic_valid/cic_data sample stream,
//                          cic_reset_n, result/result_valid/result_ready
//                          handshake, busy and sticky overrun status
// Revision    : 1.0 - initial release
// ============================================================================
module cic_conv_ctrl #(
    parameter int NUMBITS      = 25,
    parameter int DISCARD      = 3,
    parameter int FLUSH_CYCLES = 2,
    parameter int MAX_AVG_LOG2 = 4
) (
    input  wire logic   clk,
    input  wire logic   reset_n,
    cic_conv_if.slave   bus
);

    // Accumulator holds up to 2^MAX_AVG_LOG2 full-scale samples without wrap.
    localparam int ACC_W = NUMBITS + MAX_AVG_LOG2;
    localparam int CNT_W = MAX_AVG_LOG2 + 1;
    localparam int FL_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int DS_W  = (DISCARD > 1) ? $clog2(DISCARD) : 1;

    localparam logic [2:0]      c_MAX_AVG   = 3'(MAX_AVG_LOG2);
    localparam logic [FL_W-1:0] c_FLUSH_END = FL_W'(FLUSH_CYCLES - 1);
    localparam logic [DS_W-1:0] c_DISC_END  = DS_W'(DISCARD - 1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_FLUSH  = 2'd1;
    localparam logic [1:0] c_ST_SETTLE = 2'd2;
    localparam logic [1:0] c_ST_ACCUM  = 2'd3;

    logic [1:0]         r_state;
    logic               r_cont;
    logic [2:0]         r_avg_log2;
    logic [FL_W-1:0]    r_flush_cnt;
    logic [DS_W-1:0]    r_settle_cnt;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_smp_cnt;
    logic [NUMBITS-1:0] r_result;
    logic               r_result_valid;
    logic               r_overrun;
    logic               r_busy;
    logic               r_cic_reset_n;

    logic [2:0]         w_avg_clamped;
    logic [CNT_W-1:0]   w_target_m1;
    logic               w_last;
    logic [ACC_W-1:0]   w_sum;
    logic [NUMBITS-1:0] w_avg;
    logic               w_done;
    logic               w_accept;

    assign w_avg_clamped = (bus.avg_log2 > c_MAX_AVG) ? c_MAX_AVG : bus.avg_log2;

    // Sample index of the last sample in an averaging block.
    assign w_target_m1 = (CNT_W'(1) << r_avg_log2) - CNT_W'(1);
    assign w_last      = (r_smp_cnt == w_target_m1);

    // Final sum includes the sample arriving this cycle; shift truncates.
    assign w_sum = r_acc + ACC_W'(bus.cic_data);
    assign w_avg = NUMBITS'(w_sum >> r_avg_log2);

    // abort outranks a coinciding final sample, so no result is formed then.
    assign w_done   = (r_state == c_ST_ACCUM) && bus.cic_valid && !bus.abort && w_last;
    assign w_accept = r_result_valid && bus.result_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state        <= c_ST_IDLE;
            r_cont         <= 1'b0;
            r_avg_log2     <= 3'd0;
            r_flush_cnt    <= '0;
            r_settle_cnt   <= '0;
            r_acc          <= '0;
            r_smp_cnt      <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_overrun      <= 1'b0;
            r_busy         <= 1'b0;
            r_cic_reset_n  <= 1'b0;
        end else begin
            // Result register: the consumer handshake runs in every state,
            // so a result pending across abort or single-shot end survives.
            if (w_done) begin
                if (!r_result_valid || w_accept) begin
                    r_result       <= w_avg;
                    r_result_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (w_accept) begin
                r_result_valid <= 1'b0;
            end

            if (r_state == c_ST_IDLE) begin
                if (bus.start && !bus.abort) begin
                    r_cont        <= bus.continuous;
                    r_avg_log2    <= w_avg_clamped;
                    r_overrun     <= 1'b0;
                    r_flush_cnt   <= '0;
                    r_busy        <= 1'b1;
                    r_cic_reset_n <= 1'b0;
                    r_state       <= c_ST_FLUSH;
                end
            end else if (bus.abort) begin
                r_state       <= c_ST_IDLE;
                r_busy        <= 1'b0;
                r_cic_reset_n <= 1'b0;
                r_flush_cnt   <= '0;
                r_settle_cnt  <= '0;
                r_acc         <= '0;
                r_smp_cnt     <= '0;
            end else begin
                case (r_state)
                    c_ST_FLUSH: begin
                        if (r_flush_cnt == c_FLUSH_END) begin
                            r_flush_cnt   <= '0;
                            r_settle_cnt  <= '0;
                            r_cic_reset_n <= 1'b1;
                            r_state       <= c_ST_SETTLE;
                        end else begin
                            r_flush_cnt <= r_flush_cnt + FL_W'(1);
                        end
                    end
                    c_ST_SETTLE: begin
                        if (bus.cic_valid) begin
                            if (r_settle_cnt == c_DISC_END) begin
                                r_settle_cnt <= '0;
                                r_acc        <= '0;
                                r_smp_cnt    <= '0;
                                r_state      <= c_ST_ACCUM;
                            end else begin
                                r_settle_cnt <= r_settle_cnt + DS_W'(1);
                            end
                        end
                    end
                    c_ST_ACCUM: begin
                        if (bus.cic_valid) begin
                            if (w_last) begin
                                r_acc     <= '0;
                                r_smp_cnt <= '0;
                                if (!r_cont) begin
                                    r_state       <= c_ST_IDLE;
                                    r_busy        <= 1'b0;
                                    r_cic_reset_n <= 1'b0;
                                end
                            end else begin
                                r_acc     <= w_sum;
                                r_smp_cnt <= r_smp_cnt + CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.cic_reset_n  = r_cic_reset_n;
    assign bus.result       = r_result;
    assign bus.result_valid = r_result_valid;
    assign bus.busy         = r_busy;
    assign bus.overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_cic_conv_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_cic_conv_ctrl
// Description : Self-checking bench for cic_conv_ctrl. Stimulus is issued a
//               cycle at a time; completed averages are computed from the
//               sample lists and queued, and a monitor pops and compares at
//               each result handshake. Directed cases plus randomised
//               conversions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cic_conv_ctrl;

    localparam int NB   = 25;
    localparam int DISC = 3;
    localparam int FLC  = 2;
    localparam int MAXA = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    cic_conv_if #(.NUMBITS(NB)) bus();

    cic_conv_ctrl #(
        .NUMBITS      (NB),
        .DISCARD      (DISC),
        .FLUSH_CYCLES (FLC),
        .MAX_AVG_LOG2 (MAXA)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [NB-1:0] exp_q[$];
    logic [NB-1:0] mon_exp;
    bit            pending = 1'b0;
    bit            exp_ovr = 1'b0;
    bit            rnd_rdy = 1'b0;

    function automatic void check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Scoreboard monitor: every accepted result must match the queue head.
    always @(negedge clk) begin
        if (reset_n && bus.result_valid && bus.result_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL scoreboard: got %0d, expected no result", bus.result);
            end else begin
                mon_exp = exp_q.pop_front();
                check("scoreboard", longint'(bus.result), longint'(mon_exp));
            end
        end
    end

    // One clock with the given sample inputs; updates the result model.
    task automatic step(input bit v, input logic [NB-1:0] d, input bit last,
                        input logic [NB-1:0] avg);
        if (rnd_rdy) bus.result_ready = 1'($urandom_range(0, 1));
        bus.cic_valid = v;
        bus.cic_data  = d;
        if (last) begin
            if (!pending || bus.result_ready) begin
                exp_q.push_back(avg);
                pending = 1'b1;
            end else begin
                exp_ovr = 1'b1;
            end
        end else if (pending && bus.result_ready) begin
            pending = 1'b0;
        end
        @(posedge clk);
        #1;
        bus.cic_valid = 1'b0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0);
    endtask

    task automatic do_abort();
        bus.abort = 1'b1;
        step(1'b0, '0, 1'b0, '0);
        check("abort_busy", bus.busy, 0);
        check("abort_cic_rst", bus.cic_reset_n, 0);
    endtask

    task automatic drain();
        rnd_rdy = 1'b0;
        bus.result_ready = 1'b1;
        for (int i = 0; i < 20 && pending; i++) step(1'b0, '0, 1'b0, '0);
        bus.result_ready = 1'b0;
        check("drain_valid", bus.result_valid, 0);
        check("drain_queue", exp_q.size(), 0);
    endtask

    task automatic start_conv(input bit cont, input logic [2:0] a);
        bus.start      = 1'b1;
        bus.continuous = cont;
        bus.avg_log2   = a;
        exp_ovr        = 1'b0;
        step(1'b0, '0, 1'b0, '0);
        check("start_busy", bus.busy, 1);
        check("start_cic_rst", bus.cic_reset_n, 0);
        check("start_ovr_clr", bus.overrun, 0);
        idle(FLC - 1);
        check("flush_hold", bus.cic_reset_n, 0);
        idle(1);
        check("flush_release", bus.cic_reset_n, 1);
    endtask

    task automatic discard();
        for (int i = 0; i < DISC; i++) begin
            idle($urandom_range(0, 2));
            step(1'b1, NB'($urandom()), 1'b0, '0);
        end
    endtask

    // Feed one averaging block; expected average from plain arithmetic.
    task automatic send_block(input logic [NB-1:0] s[$], input int k);
        longint sum = 0;
        logic [NB-1:0] avg;
        foreach (s[i]) sum += longint'(s[i]);
        avg = NB'(sum >> k);
        foreach (s[i]) begin
            idle($urandom_range(0, 2));
            step(1'b1, s[i], (i == s.size() - 1), avg);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_cic_rst"}, bus.cic_reset_n, 0);
        check({tag, "_valid"}, bus.result_valid, 0);
        check({tag, "_result"}, bus.result, 0);
        check({tag, "_ovr"}, bus.overrun, 0);
    endtask

    task automatic do_reset();
        bus.result_ready = 1'b0;
        reset_n = 1'b0;
        step(1'b0, '0, 1'b0, '0);
        exp_q.delete();
        pending = 1'b0;
        exp_ovr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [NB-1:0] blk[$];
        bit            cont;
        logic [2:0]    a;
        int            eff;
        int            nres;

        bus.start = 0; bus.abort = 0; bus.continuous = 0; bus.avg_log2 = 0;
        bus.cic_valid = 0; bus.cic_data = 0; bus.result_ready = 0;

        do_reset();
        idle(1);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        idle(2);

        // Basic single shot: (10+20+30+40)/4
        start_conv(1'b0, 3'd2);
        discard();
        blk = '{25'd10, 25'd20, 25'd30, 25'd40};
        send_block(blk, 2);
        check("t1_valid", bus.result_valid, 1);
        check("t1_result", bus.result, 25);
        check("t1_busy", bus.busy, 0);
        check("t1_cic_rst", bus.cic_reset_n, 0);
        drain();

        // Truncation: (1+2)/2
        start_conv(1'b0, 3'd1);
        discard();
        blk = '{25'd1, 25'd2};
        send_block(blk, 1);
        check("t2_result", bus.result, 1);
        drain();

        // Clamp 7 -> 4: 16 samples of 1000
        start_conv(1'b0, 3'd7);
        discard();
        for (int i = 0; i < 16; i++) begin
            idle($urandom_range(0, 1));
            step(1'b1, 25'd1000, (i == 15), 25'd1000);
            if (i == 14) check("t3_not_early", bus.result_valid, 0);
        end
        check("t3_valid", bus.result_valid, 1);
        check("t3_result", bus.result, 1000);
        drain();

        // Overrun
        start_conv(1'b1, 3'd0);
        discard();
        bus.result_ready = 1'b0;
        step(1'b1, 25'd5, 1'b1, 25'd5);
        step(1'b1, 25'd6, 1'b1, 25'd6);
        check("t4_result", bus.result, 5);
        check("t4_ovr", bus.overrun, exp_ovr);
        check("t4_ovr_set", bus.overrun, 1);
        bus.result_ready = 1'b1;
        step(1'b0, '0, 1'b0, '0);
        bus.result_ready = 1'b0;
        check("t4_valid_clr", bus.result_valid, 0);
        do_abort();
        check("t4_ovr_kept", bus.overrun, 1);

        // Same-cycle accept and load (start also clears overrun)
        start_conv(1'b1, 3'd0);
        discard();
        step(1'b1, 25'd3, 1'b1, 25'd3);
        bus.result_ready = 1'b1;
        step(1'b1, 25'd7, 1'b1, 25'd7);
        bus.result_ready = 1'b0;
        check("t5_result", bus.result, 7);
        check("t5_valid", bus.result_valid, 1);
        check("t5_ovr", bus.overrun, 0);
        do_abort();
        drain();

        // Abort in ACCUM after 2 of 4, then clean conversion
        start_conv(1'b0, 3'd2);
        discard();
        step(1'b1, 25'd100, 1'b0, '0);
        step(1'b1, 25'd200, 1'b0, '0);
        do_abort();
        check("t6_no_result", bus.result_valid, 0);
        idle(3);
        start_conv(1'b0, 3'd2);
        discard();
        blk = '{25'd8, 25'd8, 25'd8, 25'd8};
        send_block(blk, 2);
        check("t6_result", bus.result, 8);
        drain();

        // Reset mid-FLUSH
        bus.start = 1'b1; bus.continuous = 1'b0; bus.avg_log2 = 3'd0;
        step(1'b0, '0, 1'b0, '0);
        do_reset();
        check_reset_outputs("rst_flush");
        reset_n = 1'b1;

        // Reset mid-ACCUM
        start_conv(1'b0, 3'd2);
        discard();
        step(1'b1, 25'd50, 1'b0, '0);
        do_reset();
        check_reset_outputs("rst_accum");
        reset_n = 1'b1;
        idle(1);
        start_conv(1'b0, 3'd0);
        discard();
        blk = '{25'd123};
        send_block(blk, 0);
        check("t7_result", bus.result, 123);
        drain();

        // Randomised conversions
        for (int t = 0; t < 25; t++) begin
            cont = 1'($urandom_range(0, 1));
            a    = 3'($urandom_range(0, 7));
            eff  = (int'(a) > MAXA) ? MAXA : int'(a);
            nres = cont ? int'($urandom_range(1, 3)) : 1;
            start_conv(cont, a);
            rnd_rdy = 1'b1;
            discard();
            for (int r = 0; r < nres; r++) begin
                blk.delete();
                for (int i = 0; i < (1 << eff); i++) blk.push_back(NB'($urandom()));
                send_block(blk, eff);
            end
            if (cont) begin
                for (int i = 0; i < int'($urandom_range(0, (1 << eff) - 1)); i++)
                    step(1'b1, NB'($urandom()), 1'b0, '0);
                do_abort();
            end else begin
                check("rnd_single_busy", bus.busy, 0);
            end
            rnd_rdy = 1'b0;
            check("rnd_ovr", bus.overrun, exp_ovr);
            drain();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cic_conv_ctrl.md
# cic_conv_ctrl

Conversion controller for the third-order CIC decimator that filters the sigma-delta modulator bitstream. It holds the CIC in reset between conversions and releases it on a start request. It then discards the CIC settling outputs, averages a programmable power-of-two number of decimated samples, and presents each result on a valid/ready handshake. It sits between the CIC wrapper and the register/readout logic, and supports single-shot and continuous modes.

## Interface

Parameters:
- NUMBITS, 25, width of CIC output word (unsigned).
- DISCARD, 3, number of CIC outputs dropped after CIC reset release (filter settling).
- FLUSH_CYCLES, 2, cycles the CIC reset is held low after start before release.
- MAX_AVG_LOG2, 4, maximum log2 of averaging count.

Ports:
- clk  in  1  modulator-rate clock; single clock domain.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to begin conversion; ignored unless IDLE.
- abort  in  1  terminate conversion; has priority over start and cic_valid.
- continuous  in  1  1 = repeat results until abort; 0 = one result then IDLE. Sampled with start.
- avg_log2  in  3  averaging count is 2^avg_log2; sampled with start; values > MAX_AVG_LOG2 clamp to MAX_AVG_LOG2.
- cic_valid  in  1  one-cycle pulse from CIC wrapper: cic_data is a new decimated sample.
- cic_data  in  NUMBITS  CIC decimated output.
- cic_reset_n  out  1  registered active-low reset to CIC; low in IDLE and FLUSH.
- result  out  NUMBITS  averaged result; stable while result_valid is high.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts result when result_valid & result_ready.
- busy  out  1  high whenever state != IDLE.
- overrun  out  1  sticky: a completed average was dropped because result_valid was still high.

## Operation

- States: IDLE, FLUSH, SETTLE, ACCUM.
- IDLE: cic_reset_n=0. On start, capture continuous and clamped avg_log2, clear overrun, go to FLUSH.
- FLUSH: count FLUSH_CYCLES cycles with cic_reset_n=0, then go to SETTLE. cic_reset_n goes to 1 on the same edge as entry to SETTLE.
- SETTLE: count cic_valid pulses. The DISCARD-th pulse moves the FSM to ACCUM with the accumulator at 0. Its data is not accumulated.
- ACCUM: on each cic_valid, acc += cic_data, sample count++.
  - Width: accumulator is NUMBITS+MAX_AVG_LOG2 bits unsigned, so it cannot overflow.
  - On the 2^avg_log2-th sample, the final sum is (acc + cic_data) >> avg_log2, truncated toward zero to NUMBITS bits.
  - Accumulator and count restart at 0 in the same cycle.
  - If continuous=1: stay in ACCUM, with no re-settle.
  - If continuous=0: go to IDLE (cic_reset_n=0).
- Result register:
  - If result_valid=0 when a final sum completes, load result and set result_valid.
  - If result_valid=1 and it is not being accepted in that same cycle, drop the new sum and set overrun.
  - Accept-and-load in the same cycle is legal: the new sum loads, result_valid stays 1, and overrun is not set.
- result_valid clears on the cycle after acceptance, unless a new sum loads in that cycle.
- abort in any non-IDLE state: go to IDLE next edge, cic_reset_n=0, discard accumulator and counters. A pending result and overrun are retained.
- cic_valid is ignored in IDLE and FLUSH.
- start while busy is ignored. Mode and avg_log2 changes take effect only at the next start.

## Timing

- Reset (reset_n=0 at a clk edge): state=IDLE, cic_reset_n=0, result=0, result_valid=0, busy=0, overrun=0, all counters/accumulator=0. Reset mid-conversion behaves identically.
- start at edge N: busy=1 and cic_reset_n=0 after edge N. cic_reset_n=1 after edge N+FLUSH_CYCLES.
- Result latency: result_valid=1 one cycle after the clk edge that samples the final cic_valid.
- Single-shot: busy falls on the same edge that raises result_valid.
- abort at edge M: busy=0 and cic_reset_n=0 after edge M.
- No combinational path from any input to any output; all outputs are registered.

## Test plan

- Single-shot, avg_log2=2, DISCARD=3:
  - Stimulus: cic_valid samples 99,99,99 (discarded), then 10,20,30,40.
  - Required: result=25 with result_valid one cycle after the 40 sample; busy=0 at the same edge; cic_reset_n=0 afterward.
- Truncation and clamp:
  - avg_log2=1 with samples 1,2 → result=1.
  - avg_log2=7 → clamped to 4: 16 samples of 1000 each → result=1000, with result_valid only after the 16th sample.
- Overrun:
  - Stimulus: continuous, avg_log2=0, result_ready=0, samples 5 then 6.
  - Required: result stays 5 and overrun=1.
  - Then result_ready=1 for one cycle → result_valid=0.
  - Next start clears overrun.
- Same-cycle accept and load: continuous, avg_log2=0, result_ready=1 coincident with the next sample 7 → result=7, result_valid stays 1, overrun=0.
- Abort during ACCUM after 2 of 4 samples:
  - busy=0 and cic_reset_n=0 next cycle; no result produced.
  - A later start with samples 8,8,8,8 after settling → result=8, with no residue from the aborted conversion.
- Reset mid-FLUSH and mid-ACCUM: all outputs return to reset values at the following edge; start during IDLE after reset is honoured normally.
